key_autorepeat: RTL

- Consumes the one-cycle press/release event pulses produced by the button debouncer and turns them into game-move step pulses with delayed auto-shift (DAS) and auto-repeat rate (ARR) behaviour.
- One instance per directional key (left/right/down) sits between the debouncer and the tetris game-logic FSM.
- The game logic sees a `step` pulse on the press, then a repeat train while the key stays held.

---
 rtl/key_autorepeat_if.sv | 11 +
 rtl/key_autorepeat.sv | 73 +++++++
 2 files changed

// File: rtl/key_autorepeat_if.sv
// key_autorepeat_if: key event inputs and step/held/repeat outputs of one key_autorepeat instance.
interface key_autorepeat_if;
    logic       press_i;
    logic       release_i;
    logic       hold_en_i;
    logic       step_o;
    logic       held_o;
    logic [7:0] repeat_cnt_o;
    modport master (output press_i, release_i, hold_en_i, input step_o, held_o, repeat_cnt_o);
    modport slave  (input press_i, release_i, hold_en_i, output step_o, held_o, repeat_cnt_o);
endinterface

// File: rtl/key_autorepeat.sv
// key_autorepeat: turns debounced press/release pulses into step pulses with DAS delay and ARR repeat.
module key_autorepeat #(
    parameter int unsigned DAS_TICKS = 400000,
    parameter int unsigned ARR_TICKS = 125000,
    parameter int unsigned CNT_W     = 20
) (
    input  logic           clk,
    input  logic           rst_n,
    key_autorepeat_if.slave kif
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;
    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_TICKS - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_TICKS - 1);
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             step_q;
    logic             held_q;
    logic [7:0]       rcnt_q;
    logic [7:0]       rcnt_d;
    assign rcnt_d = (rcnt_q == 8'hFF) ? rcnt_q : rcnt_q + 8'd1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
            held_q  <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            step_q <= 1'b0;
            // release beats a simultaneous press; both are ignored while idle
            if (kif.release_i && state_q != IDLE) begin
                state_q <= IDLE;
                held_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (kif.press_i && !kif.release_i) begin
                state_q <= DELAY;
                step_q  <= 1'b1;
                held_q  <= 1'b1;
                cnt_q   <= '0;
                rcnt_q  <= '0;
            end else begin
                case (state_q)
                    DELAY: begin
                        if (cnt_q == DAS_LAST) begin
                            cnt_q   <= '0;
                            state_q <= kif.hold_en_i ? REPEAT : HOLD;
                            step_q  <= kif.hold_en_i;
                            if (kif.hold_en_i) rcnt_q <= rcnt_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!kif.hold_en_i) begin
                            state_q <= HOLD;
                            cnt_q   <= '0;
                        end else if (cnt_q == ARR_LAST) begin
                            step_q <= 1'b1;
                            cnt_q  <= '0;
                            rcnt_q <= rcnt_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    assign kif.step_o       = step_q;
    assign kif.held_o       = held_q;
    assign kif.repeat_cnt_o = rcnt_q;
endmodule
